// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator core and its result serializer.
package acc_pkg;

  localparam int unsigned ACC_IN_WIDTH = 8;
  localparam int unsigned ACC_DWIDTH   = 16;

  typedef enum logic {
    IDLE,
    SEND
  } TX_STATE;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/acc_result_tx_if.sv
// Byte-stream valid/ready link carrying serialized accumulator results.
interface acc_result_tx_if #(
  parameter int unsigned OUT_WIDTH = 8
);

  logic [OUT_WIDTH-1:0] byte_o;
  logic                 byte_valid_o;
  logic                 byte_ready_i;
  logic                 last_o;

  modport master (
    output byte_o,
    output byte_valid_o,
    output last_o,
    input  byte_ready_i
  );

  modport slave (
    input  byte_o,
    input  byte_valid_o,
    input  last_o,
    output byte_ready_i
  );

endinterface

// File: rtl/acc_word_fifo.sv
// Single-clock word FIFO; head word is visible combinationally on rdata.
module acc_word_fifo
  import acc_pkg::*;
#(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 push,
  input  logic [DWIDTH-1:0]                    wdata,
  input  logic                                 pop,
  output logic [DWIDTH-1:0]                    rdata,
  output logic                                 full,
  output logic                                 empty,
  output logic [count_width(FIFO_DEPTH)-1:0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = count_width(FIFO_DEPTH);

  logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Gating on the registered flags keeps a same-cycle pop from freeing a slot.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/acc_result_tx.sv
// Buffers acc_core results and serializes each word MSB byte first onto a
// stallable valid/ready byte link.
module acc_result_tx
  import acc_pkg::*;
#(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               valid_i,
  input  logic [DWIDTH-1:0]                  result_i,
  acc_result_tx_if.master                    tx,
  output logic [count_width(FIFO_DEPTH)-1:0] fifo_count_o,
  output logic                               overflow_o,
  input  logic                               clear_ovf_i
);

  localparam int unsigned BYTES = DWIDTH / OUT_WIDTH;
  localparam int unsigned IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  TX_STATE           state_q, state_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              ovf_q, ovf_d;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_rdata;

  acc_word_fifo #(
    .DWIDTH    (DWIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (valid_i),
    .wdata (result_i),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_o)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        // byte_valid_o is high throughout SEND, so ready alone marks a handshake.
        if (tx.byte_ready_i) begin
          if (idx_q != LAST_IDX) begin
            shift_d = shift_q << OUT_WIDTH;
            idx_d   = idx_q + IW'(1);
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            idx_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (valid_i && fifo_full) ovf_d = 1'b1;
    else if (clear_ovf_i)     ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx.byte_o       = shift_q[DWIDTH-1 -: OUT_WIDTH];
  assign tx.byte_valid_o = (state_q == SEND);
  assign tx.last_o       = (state_q == SEND) && (idx_q == LAST_IDX);
  assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_acc_result_tx.sv
// Self-checking bench for acc_result_tx against a queue-based byte-stream model.
module tb_acc_result_tx;

  localparam int unsigned DW    = 16;
  localparam int unsigned OW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i;
  logic [DW-1:0] result_i;
  logic          clear_ovf_i;
  logic [2:0]    fifo_count_o;
  logic          overflow_o;

  int checks   = 0;
  int failures = 0;

  acc_result_tx_if #(.OUT_WIDTH(OW)) tx ();

  acc_result_tx #(
    .DWIDTH    (DW),
    .OUT_WIDTH (OW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (valid_i),
    .result_i    (result_i),
    .tx          (tx),
    .fifo_count_o(fifo_count_o),
    .overflow_o  (overflow_o),
    .clear_ovf_i (clear_ovf_i)
  );

  always #5 clk = ~clk;

  // Reference model: queued words, remaining bytes of the word on the link,
  // sticky drop flag, and the list of every accepted word.
  logic [DW-1:0] m_fifo[$];
  logic [OW-1:0] m_cur[$];
  logic [DW-1:0] m_accepted[$];
  bit            m_ovf;

  task automatic model_reset();
    m_fifo.delete();
    m_cur.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_load();
    logic [DW-1:0] w;
    w = m_fifo.pop_front();
    m_cur.push_back(w[15:8]);
    m_cur.push_back(w[7:0]);
  endtask

  task automatic model_edge();
    bit full, had;
    full = (m_fifo.size() == DEPTH);
    had  = (m_fifo.size() > 0);
    if (m_cur.size() == 0) begin
      if (had) model_load();
    end else if (tx.byte_ready_i) begin
      void'(m_cur.pop_front());
      if (m_cur.size() == 0 && had) model_load();
    end
    if (valid_i && !full) begin
      m_fifo.push_back(result_i);
      m_accepted.push_back(result_i);
    end
    if (valid_i && full)  m_ovf = 1'b1;
    else if (clear_ovf_i) m_ovf = 1'b0;
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit rdy, input bit clr);
    valid_i = v; result_i = d; tx.byte_ready_i = rdy; clear_ovf_i = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid_i = 1'b0; clear_ovf_i = 1'b0; tx.byte_ready_i = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (tx.byte_o !== 8'h00) begin failures++; $display("FAIL reset byte_o got=%h exp=00", tx.byte_o); end
    checks++; if (tx.byte_valid_o !== 1'b0) begin failures++; $display("FAIL reset byte_valid_o got=%b exp=0", tx.byte_valid_o); end
    checks++; if (tx.last_o !== 1'b0) begin failures++; $display("FAIL reset last_o got=%b exp=0", tx.last_o); end
    checks++; if (fifo_count_o !== 3'd0) begin failures++; $display("FAIL reset fifo_count got=%0d exp=0", fifo_count_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset overflow got=%b exp=0", overflow_o); end
    do_reset();
    checks++; if (tx.byte_valid_o !== 1'b0 || fifo_count_o !== 3'd0) begin
      failures++; $display("FAIL reset_release valid=%b count=%0d exp 0/0", tx.byte_valid_o, fifo_count_o);
    end
  endtask

  task automatic test_single_word();
    cycle(1, 16'hA55A, 1, 0);
    checks++; if (fifo_count_o !== 3'd1) begin failures++; $display("FAIL single count got=%0d exp=1", fifo_count_o); end
    checks++; if (tx.byte_valid_o !== 1'b0) begin failures++; $display("FAIL single early_valid got=%b exp=0", tx.byte_valid_o); end
    cycle(0, '0, 1, 0);
    checks++; if (tx.byte_valid_o !== 1'b1 || tx.byte_o !== 8'hA5 || tx.last_o !== 1'b0) begin
      failures++; $display("FAIL single msb got v=%b b=%h l=%b exp v=1 b=a5 l=0", tx.byte_valid_o, tx.byte_o, tx.last_o);
    end
    cycle(0, '0, 1, 0);
    checks++; if (tx.byte_valid_o !== 1'b1 || tx.byte_o !== 8'h5A || tx.last_o !== 1'b1) begin
      failures++; $display("FAIL single lsb got v=%b b=%h l=%b exp v=1 b=5a l=1", tx.byte_valid_o, tx.byte_o, tx.last_o);
    end
    cycle(0, '0, 1, 0);
    checks++; if (tx.byte_valid_o !== 1'b0) begin failures++; $display("FAIL single done_valid got=%b exp=0", tx.byte_valid_o); end
  endtask

  task automatic test_backpressure();
    cycle(1, 16'h1234, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, '0, 0, 0);
      checks++; if (tx.byte_valid_o !== 1'b1 || tx.byte_o !== 8'h12 || tx.last_o !== 1'b0) begin
        failures++; $display("FAIL stall[%0d] got v=%b b=%h l=%b exp v=1 b=12 l=0", i, tx.byte_valid_o, tx.byte_o, tx.last_o);
      end
    end
    cycle(0, '0, 1, 0);
    checks++; if (tx.byte_valid_o !== 1'b1 || tx.byte_o !== 8'h34 || tx.last_o !== 1'b1) begin
      failures++; $display("FAIL release lsb got v=%b b=%h l=%b exp v=1 b=34 l=1", tx.byte_valid_o, tx.byte_o, tx.last_o);
    end
    cycle(0, '0, 1, 0);
    checks++; if (tx.byte_valid_o !== 1'b0) begin failures++; $display("FAIL release done got=%b exp=0", tx.byte_valid_o); end
  endtask

  task automatic test_burst();
    logic [DW-1:0] got_words[$];
    logic [OW-1:0] hi;
    do_reset();
    m_accepted.delete();
    hi = '0;
    for (int i = 2; i < 92; i++) begin
      if (tx.byte_valid_o === 1'b1) begin
        if (tx.last_o === 1'b1) got_words.push_back({hi, tx.byte_o});
        else hi = tx.byte_o;
      end
      if (i < 72) cycle(1, DW'(i), 1, 0);
      else        cycle(0, '0, 1, 0);
      checks++; if (tx.byte_valid_o !== (m_cur.size() > 0)) begin failures++; $display("FAIL burst valid got=%b exp=%b", tx.byte_valid_o, m_cur.size() > 0); end
      if (m_cur.size() > 0) begin
        checks++; if (tx.byte_o !== m_cur[0]) begin failures++; $display("FAIL burst byte got=%h exp=%h", tx.byte_o, m_cur[0]); end
      end
      checks++; if (tx.last_o !== (m_cur.size() == 1)) begin failures++; $display("FAIL burst last got=%b exp=%b", tx.last_o, m_cur.size() == 1); end
      checks++; if (fifo_count_o !== 3'(m_fifo.size())) begin failures++; $display("FAIL burst count got=%0d exp=%0d", fifo_count_o, m_fifo.size()); end
      checks++; if (overflow_o !== m_ovf) begin failures++; $display("FAIL burst ovf got=%b exp=%b", overflow_o, m_ovf); end
    end
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL burst sticky_ovf got=%b exp=1", overflow_o); end
    checks++; if (got_words.size() != m_accepted.size()) begin
      failures++; $display("FAIL burst word_count got=%0d exp=%0d", got_words.size(), m_accepted.size());
    end else begin
      for (int k = 0; k < got_words.size(); k++) begin
        checks++; if (got_words[k] !== m_accepted[k]) begin failures++; $display("FAIL burst word[%0d] got=%h exp=%h", k, got_words[k], m_accepted[k]); end
      end
    end
  endtask

  task automatic test_overflow_clear();
    cycle(0, '0, 1, 1);
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow_o); end
    for (int i = 0; i < 10 && m_fifo.size() < DEPTH; i++) cycle(1, DW'($urandom), 0, 0);
    checks++; if (fifo_count_o !== 3'd4) begin failures++; $display("FAIL ovf_fill count got=%0d exp=4", fifo_count_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_fill ovf got=%b exp=0", overflow_o); end
    cycle(1, 16'hDEAD, 0, 1);
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow_o); end
    checks++; if (fifo_count_o !== 3'd4) begin failures++; $display("FAIL ovf_drop count got=%0d exp=4", fifo_count_o); end
    for (int i = 0; i < 14; i++) begin
      cycle(0, '0, 1, 0);
      checks++; if (tx.byte_valid_o !== (m_cur.size() > 0)) begin failures++; $display("FAIL drain valid got=%b exp=%b", tx.byte_valid_o, m_cur.size() > 0); end
      if (m_cur.size() > 0) begin
        checks++; if (tx.byte_o !== m_cur[0]) begin failures++; $display("FAIL drain byte got=%h exp=%h", tx.byte_o, m_cur[0]); end
      end
      checks++; if (fifo_count_o !== 3'(m_fifo.size())) begin failures++; $display("FAIL drain count got=%0d exp=%0d", fifo_count_o, m_fifo.size()); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[3];
    logic [OW-1:0] exp_b;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w[i] = DW'($urandom);
      cycle(1, w[i], 0, 0);
    end
    cycle(0, '0, 0, 0);
    for (int j = 0; j < 6; j++) begin
      exp_b = (j % 2 == 0) ? w[j/2][15:8] : w[j/2][7:0];
      checks++; if (tx.byte_valid_o !== 1'b1 || tx.byte_o !== exp_b || tx.last_o !== (j % 2 == 1)) begin
        failures++; $display("FAIL b2b[%0d] got v=%b b=%h l=%b exp v=1 b=%h l=%b", j, tx.byte_valid_o, tx.byte_o, tx.last_o, exp_b, j % 2 == 1);
      end
      cycle(0, '0, 1, 0);
    end
    checks++; if (tx.byte_valid_o !== 1'b0) begin failures++; $display("FAIL b2b end valid got=%b exp=0", tx.byte_valid_o); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    cycle(1, 16'hBEEF, 1, 0);
    cycle(0, '0, 1, 0);
    checks++; if (tx.byte_o !== 8'hBE || tx.byte_valid_o !== 1'b1) begin failures++; $display("FAIL mid msb got=%h v=%b exp=be v=1", tx.byte_o, tx.byte_valid_o); end
    cycle(0, '0, 1, 0);
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (tx.byte_o !== 8'h00 || tx.byte_valid_o !== 1'b0 || tx.last_o !== 1'b0 || fifo_count_o !== 3'd0 || overflow_o !== 1'b0) begin
      failures++; $display("FAIL mid async_reset got b=%h v=%b l=%b c=%0d o=%b exp all 0", tx.byte_o, tx.byte_valid_o, tx.last_o, fifo_count_o, overflow_o);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 1, 0);
      checks++; if (tx.byte_valid_o !== 1'b0) begin failures++; $display("FAIL mid stale_byte got v=%b b=%h exp v=0", tx.byte_valid_o, tx.byte_o); end
    end
    cycle(1, 16'h1357, 1, 0);
    cycle(0, '0, 1, 0);
    checks++; if (tx.byte_valid_o !== 1'b1 || tx.byte_o !== 8'h13 || tx.last_o !== 1'b0) begin
      failures++; $display("FAIL mid post msb got v=%b b=%h l=%b exp v=1 b=13 l=0", tx.byte_valid_o, tx.byte_o, tx.last_o);
    end
    cycle(0, '0, 1, 0);
    checks++; if (tx.byte_valid_o !== 1'b1 || tx.byte_o !== 8'h57 || tx.last_o !== 1'b1) begin
      failures++; $display("FAIL mid post lsb got v=%b b=%h l=%b exp v=1 b=57 l=1", tx.byte_valid_o, tx.byte_o, tx.last_o);
    end
    cycle(0, '0, 1, 0);
    checks++; if (tx.byte_valid_o !== 1'b0) begin failures++; $display("FAIL mid post end got=%b exp=0", tx.byte_valid_o); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 45, DW'($urandom), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5);
      checks++; if (tx.byte_valid_o !== (m_cur.size() > 0)) begin failures++; $display("FAIL rand[%0d] valid got=%b exp=%b", i, tx.byte_valid_o, m_cur.size() > 0); end
      if (m_cur.size() > 0) begin
        checks++; if (tx.byte_o !== m_cur[0]) begin failures++; $display("FAIL rand[%0d] byte got=%h exp=%h", i, tx.byte_o, m_cur[0]); end
      end
      checks++; if (tx.last_o !== (m_cur.size() == 1)) begin failures++; $display("FAIL rand[%0d] last got=%b exp=%b", i, tx.last_o, m_cur.size() == 1); end
      checks++; if (fifo_count_o !== 3'(m_fifo.size())) begin failures++; $display("FAIL rand[%0d] count got=%0d exp=%0d", i, fifo_count_o, m_fifo.size()); end
      checks++; if (overflow_o !== m_ovf) begin failures++; $display("FAIL rand[%0d] ovf got=%b exp=%b", i, overflow_o, m_ovf); end
    end
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; result_i = '0; clear_ovf_i = 1'b0; tx.byte_ready_i = 1'b0;
    model_reset();
    test_reset();
    test_single_word();
    test_backpressure();
    test_burst();
    test_overflow_clear();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
